reg_scoreboard: RTL

- Parametrised register scoreboard. It is the successor to the fixed 5-stage hazard-detection/forwarding logic.
- Tracks in-flight destination registers, each with a per-register remaining-latency counter. This supports variable-latency functional units such as a multi-cycle multiplier/divider or a slow memory.
- Generates the decode-stage stall for RAW and WAW hazards.
- Sits beside the ID stage. The stall output drives PCwrite/IFID_write deassertion and bubble insertion into ID/EX.

---
 rtl/reg_scoreboard.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Register scoreboard for the decode stage. Each architectural register
// (except r0, which is hard-wired zero) owns a small down-counter holding the
// number of cycles until its pending result becomes forwardable. The block
// blocks issue on read-after-write hazards (a source is still pending) and on
// write-after-write hazards (an older write would land after a younger one).
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   issue_valid  instruction in ID requests issue this cycle
//   issue_wr     instruction writes a destination register
//   issue_rd     destination register
//   issue_lat    cycles until result is forwardable (0 = immediately)
//   src_used     per-operand valid mask
//   src_addr     packed source addresses, operand i at [i*REG_AW +: REG_AW]
//   hold         global pipeline freeze; counters frozen, no issue recorded
//   flush        drop all in-flight tracking
//   stall        issue blocked this cycle (combinational)
//   issue_ack    issue accepted this cycle (combinational)
//   busy_vec     registered per-register busy flags
//   in_flight    registered number of busy registers
//   stall_count  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NREG    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MAX_LAT = 15,
    parameter int CW      = 4,
    parameter int PCW     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic                        issue_wr,
    input  logic [REG_AW-1:0]           issue_rd,
    input  logic [CW-1:0]               issue_lat,
    input  logic [NUM_SRC-1:0]          src_used,
    input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
    input  logic                        hold,
    input  logic                        flush,
    output logic                        stall,
    output logic                        issue_ack,
    output logic [NREG-1:0]             busy_vec,
    output logic [REG_AW:0]             in_flight,
    output logic [PCW-1:0]              stall_count
);

    localparam logic [CW-1:0] MAX_LAT_C = CW'(MAX_LAT);

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [NREG-1:0] busy_vec_q;
    logic [NREG-1:0] busy_vec_d;
    logic [REG_AW:0] in_flight_q;
    logic [REG_AW:0] in_flight_d;
    logic [PCW-1:0]  stall_count_q;
    logic [PCW-1:0]  stall_count_d;

    logic            raw_s;
    logic            waw_s;
    logic [CW-1:0]   lat_clamp_s;

    // RAW detection: any used, non-zero source whose counter is still running.
    always_comb begin
        raw_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used[i] && (src_addr[i*REG_AW +: REG_AW] != '0) &&
                (cnt_q[src_addr[i*REG_AW +: REG_AW]] != '0)) begin
                raw_s = 1'b1;
            end else begin
                raw_s = raw_s;
            end
        end
    end

    // WAW detection, stall/acknowledge and latency clamp.
    // Counters never exceed MAX_LAT, so comparing against the raw latency
    // gives the same answer as comparing against the clamped one.
    always_comb begin
        waw_s       = issue_wr && (issue_rd != '0) && (cnt_q[issue_rd] > issue_lat);
        stall       = issue_valid && (raw_s || waw_s);
        issue_ack   = issue_valid && !stall && !hold && !flush;
        if (issue_lat > MAX_LAT_C) begin
            lat_clamp_s = MAX_LAT_C;
        end else begin
            lat_clamp_s = issue_lat;
        end
    end

    // Counter next state: flush clears, hold freezes, otherwise count down and
    // let a newly accepted write override the decrement of its own register.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r] = '0;
            end
        end else if (hold) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r] = cnt_q[r];
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CW'(1);
                end else begin
                    cnt_d[r] = '0;
                end
            end
            if (issue_ack && issue_wr && (issue_rd != '0)) begin
                cnt_d[issue_rd] = lat_clamp_s;
            end else begin
                cnt_d[issue_rd] = cnt_d[issue_rd];
            end
        end
        cnt_d[0] = '0;
    end

    // Busy flags and population count taken from the next-state counters so
    // both registered views agree in the same cycle.
    always_comb begin
        in_flight_d = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec_d[r] = (cnt_d[r] != '0);
            in_flight_d   = in_flight_d + (REG_AW+1)'(busy_vec_d[r]);
        end
    end

    // Saturating count of cycles in which a real (non-frozen) stall happened.
    always_comb begin
        if (stall && !hold && !flush && (stall_count_q != {PCW{1'b1}})) begin
            stall_count_d = stall_count_q + PCW'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            busy_vec_q    <= '0;
            in_flight_q   <= '0;
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_vec_q    <= busy_vec_d;
            in_flight_q   <= in_flight_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign busy_vec    = busy_vec_q;
    assign in_flight   = in_flight_q;
    assign stall_count = stall_count_q;

endmodule
